// File: rtl/fetchq_pkg.sv
// Shared types and constants for the instruction-pair prefetch queue.
package fetchq_pkg;

    localparam int FQ_AW = 9;
    localparam int FQ_IW = 16;

    typedef struct packed {
        logic [FQ_IW-1:0] ir0;
        logic [FQ_IW-1:0] ir1;
        logic [FQ_AW-1:0] pc;
        logic             ir0_invalid;
    } fetchq_entry_t;

endpackage

// File: rtl/fetchq_checker.sv
// Protocol checks for the prefetch queue storage.
module fetchq_checker (
    input logic clk,
    input logic clear,
    input logic push,
    input logic full
);

    // The request throttle must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (clear) !(push && full))
        else $error("fetchq_store: push into full queue");

endmodule

// File: rtl/fetchq_store.sv
// DEPTH-entry circular register storage for instruction pairs (push/pop/clear).
module fetchq_store
    import fetchq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int OW = PW + 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  fetchq_entry_t wdata,
    output fetchq_entry_t rdata,
    output logic [OW-1:0] occupancy,
    output logic          empty
);

    fetchq_entry_t mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [OW-1:0] count_r;
    logic          full_s;

    // Pointer and occupancy bookkeeping; clear discards everything.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {OW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + OW'(1);
                2'b01:   count_r <= count_r - OW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage needs no reset: reads are qualified by occupancy.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata     = mem_r[rd_ptr_r];
    assign occupancy = count_r;
    assign empty     = (count_r == {OW{1'b0}});
    assign full_s    = (count_r == OW'(DEPTH));

    fetchq_checker u_checker (
        .clk   (clk),
        .clear (clear),
        .push  (push),
        .full  (full_s)
    );

endmodule

// File: rtl/fetch_queue.sv
// Dual-slot instruction prefetch queue with redirect flush.
// Optional same-cycle bypass of responses into an empty queue: FETCHQ_BYPASS_EN.
module fetch_queue
    import fetchq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = FQ_AW,
    parameter int IW    = FQ_IW,
    localparam int OW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          im_ena,
    output logic [AW-1:0] im_addr0,
    output logic [AW-1:0] im_addr1,
    input  logic [IW-1:0] im_rdata0,
    input  logic [IW-1:0] im_rdata1,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          issue_ready,
    output logic          issue_valid,
    output logic [IW-1:0] issue_ir0,
    output logic [IW-1:0] issue_ir1,
    output logic [AW-1:0] issue_pc,
    output logic          issue_ir0_invalid,
    output logic [OW-1:0] occupancy
);

    logic [AW-1:0] fpc_r;
    logic [AW-1:0] req_pc_r;
    logic          inflight_r;
    logic          pend_inv_r;

    fetchq_entry_t head_s;
    fetchq_entry_t resp_entry_s;
    fetchq_entry_t out_entry_s;
    logic [OW-1:0] occ_s;
    logic [OW:0]   need_s;
    logic          empty_s;
    logic          im_ena_s;
    logic          resp_s;
    logic          push_s;
    logic          pop_s;
    logic          clear_s;
    logic          issue_valid_s;

    assign clear_s  = rst || redirect_valid;
    // One extra bit so occupancy + inflight + 1 cannot wrap for small DEPTH.
    assign need_s   = {1'b0, occ_s} + {{OW{1'b0}}, inflight_r} + {{OW{1'b0}}, 1'b1};
    assign im_ena_s = !rst && !redirect_valid && (need_s <= (OW+1)'(DEPTH));
    assign resp_s   = inflight_r && !clear_s;

    // Response record and head selection, including the optional bypass path.
    always_comb begin
        resp_entry_s.ir0         = im_rdata0;
        resp_entry_s.ir1         = im_rdata1;
        resp_entry_s.pc          = req_pc_r;
        resp_entry_s.ir0_invalid = pend_inv_r;
        issue_valid_s            = !empty_s;
        out_entry_s              = head_s;
        push_s                   = resp_s;
`ifdef FETCHQ_BYPASS_EN
        if (empty_s && resp_s) begin
            issue_valid_s = 1'b1;
            out_entry_s   = resp_entry_s;
            push_s        = !issue_ready;
        end else begin
            push_s = resp_s;
        end
`endif
        pop_s = !empty_s && issue_ready;
    end

    // Fetch PC, in-flight tracking and the pending slot-0-invalid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_r      <= {AW{1'b0}};
            req_pc_r   <= {AW{1'b0}};
            inflight_r <= 1'b0;
            pend_inv_r <= 1'b0;
        end else if (redirect_valid) begin
            fpc_r      <= {redirect_pc[AW-1:1], 1'b0};
            inflight_r <= 1'b0;
            pend_inv_r <= redirect_pc[0];
        end else begin
            inflight_r <= im_ena_s;
            if (im_ena_s) begin
                fpc_r    <= fpc_r + AW'(2);
                req_pc_r <= fpc_r;
            end
            if (resp_s) begin
                pend_inv_r <= 1'b0;
            end
        end
    end

    fetchq_store #(.DEPTH(DEPTH)) u_store (
        .clk       (clk),
        .clear     (clear_s),
        .push      (push_s),
        .pop       (pop_s),
        .wdata     (resp_entry_s),
        .rdata     (head_s),
        .occupancy (occ_s),
        .empty     (empty_s)
    );

    assign im_ena            = im_ena_s;
    assign im_addr0          = {fpc_r[AW-1:1], 1'b0};
    assign im_addr1          = {fpc_r[AW-1:1], 1'b1};
    assign occupancy         = occ_s;
    // Head fields read as zero when nothing is presented.
    assign issue_valid       = issue_valid_s;
    assign issue_ir0         = issue_valid_s ? out_entry_s.ir0 : {IW{1'b0}};
    assign issue_ir1         = issue_valid_s ? out_entry_s.ir1 : {IW{1'b0}};
    assign issue_pc          = issue_valid_s ? out_entry_s.pc : {AW{1'b0}};
    assign issue_ir0_invalid = issue_valid_s && out_entry_s.ir0_invalid;

endmodule
